// File: rtl/fpu_add_sequencer.sv
// fpu_add_sequencer: three-stage valid/ready pipeline controller around external FP add step datapaths.
module fpu_add_sequencer #(
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_sub,
  input  logic [2:0]       in_frm,
  input  logic [2:0]       csr_frm,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      s1_op_a,
  output logic [31:0]      s1_op_b,
  input  logic             s1_sign_shifted,
  input  logic             s1_sign_not_shifted,
  input  logic [25:0]      s1_frac_shifted,
  input  logic [25:0]      s1_frac_not_shifted,
  input  logic [7:0]       s1_exp_max,
  output logic             s2_sign_shifted,
  output logic             s2_sign_not_shifted,
  output logic [25:0]      s2_frac_shifted,
  output logic [25:0]      s2_frac_not_shifted,
  input  logic             s2_sign_out,
  input  logic [25:0]      s2_frac_out,
  input  logic             s2_carry_out,
  output logic [2:0]       s3_frm,
  output logic [7:0]       s3_exp_max_in,
  output logic             s3_sign_in,
  output logic [25:0]      s3_frac_in,
  output logic             s3_carry_out,
  input  logic [31:0]      s3_fp_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal_rm,
  output logic [1:0]       inflight
);
  logic             va, vb, vc;
  logic             adv_a, adv_b, adv_c;
  logic [2:0]       rm_raw, rm_in;
  logic             ill_in;
  logic [7:0]       a_exp;
  logic [2:0]       a_frm;
  logic             a_ill, b_ill;
  logic [TAG_W-1:0] a_tag, b_tag;
  assign adv_c     = !vc | out_ready;
  assign adv_b     = !vb | adv_c;
  assign adv_a     = !va | adv_b;
  assign in_ready  = adv_a & !flush;
  assign out_valid = vc;
  assign inflight  = {1'b0, va} + {1'b0, vb} + {1'b0, vc};
  assign s1_op_a   = in_a;
  assign s1_op_b   = {in_b[31] ^ in_sub, in_b[30:0]};
  // Reserved modes (101, 110, and a dynamic 111 from the CSR) still run, as RNE.
  assign rm_raw    = (in_frm == 3'b111) ? csr_frm : in_frm;
  assign ill_in    = rm_raw >= 3'd5;
  assign rm_in     = ill_in ? 3'b000 : rm_raw;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      va <= 1'b0;
      vb <= 1'b0;
      vc <= 1'b0;
    end else if (flush) begin
      va <= 1'b0;
      vb <= 1'b0;
      vc <= 1'b0;
    end else begin
      if (adv_a) va <= in_valid & in_ready;
      if (adv_b) vb <= va;
      if (adv_c) vc <= vb;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_sign_shifted     <= 1'b0;
      s2_sign_not_shifted <= 1'b0;
      s2_frac_shifted     <= '0;
      s2_frac_not_shifted <= '0;
      a_exp               <= '0;
      a_frm               <= '0;
      a_ill               <= 1'b0;
      a_tag               <= '0;
    end else if (adv_a) begin
      s2_sign_shifted     <= s1_sign_shifted;
      s2_sign_not_shifted <= s1_sign_not_shifted;
      s2_frac_shifted     <= s1_frac_shifted;
      s2_frac_not_shifted <= s1_frac_not_shifted;
      a_exp               <= s1_exp_max;
      a_frm               <= rm_in;
      a_ill               <= ill_in;
      a_tag               <= in_tag;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s3_sign_in    <= 1'b0;
      s3_frac_in    <= '0;
      s3_carry_out  <= 1'b0;
      s3_exp_max_in <= '0;
      s3_frm        <= '0;
      b_ill         <= 1'b0;
      b_tag         <= '0;
    end else if (adv_b) begin
      s3_sign_in    <= s2_sign_out;
      s3_frac_in    <= s2_frac_out;
      s3_carry_out  <= s2_carry_out;
      s3_exp_max_in <= a_exp;
      s3_frm        <= a_frm;
      b_ill         <= a_ill;
      b_tag         <= a_tag;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_result     <= '0;
      out_tag        <= '0;
      out_illegal_rm <= 1'b0;
    end else if (adv_c) begin
      out_result     <= s3_fp_out;
      out_tag        <= b_tag;
      out_illegal_rm <= b_ill;
    end
  end
endmodule

// File: tb/tb_fpu_add_sequencer.sv
// tb_fpu_add_sequencer: directed vectors through the sequencer with a small behavioural FP add datapath.
module tb_fpu_add_sequencer;
  logic        CLK, RST, flush, in_valid, in_ready, in_sub, out_valid, out_ready, out_illegal_rm;
  logic [31:0] in_a, in_b, s1_op_a, s1_op_b, s3_fp_out, out_result;
  logic [2:0]  in_frm, csr_frm, s3_frm;
  logic [4:0]  in_tag, out_tag;
  logic        s1_sign_shifted, s1_sign_not_shifted, s2_sign_shifted, s2_sign_not_shifted;
  logic [25:0] s1_frac_shifted, s1_frac_not_shifted, s2_frac_shifted, s2_frac_not_shifted;
  logic [7:0]  s1_exp_max, s3_exp_max_in;
  logic        s2_sign_out, s2_carry_out, s3_sign_in, s3_carry_out;
  logic [25:0] s2_frac_out, s3_frac_in;
  logic [1:0]  inflight;

  fpu_add_sequencer #(.TAG_W(5)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_frm(in_frm), .csr_frm(csr_frm), .in_tag(in_tag),
    .s1_op_a(s1_op_a), .s1_op_b(s1_op_b),
    .s1_sign_shifted(s1_sign_shifted), .s1_sign_not_shifted(s1_sign_not_shifted),
    .s1_frac_shifted(s1_frac_shifted), .s1_frac_not_shifted(s1_frac_not_shifted), .s1_exp_max(s1_exp_max),
    .s2_sign_shifted(s2_sign_shifted), .s2_sign_not_shifted(s2_sign_not_shifted),
    .s2_frac_shifted(s2_frac_shifted), .s2_frac_not_shifted(s2_frac_not_shifted),
    .s2_sign_out(s2_sign_out), .s2_frac_out(s2_frac_out), .s2_carry_out(s2_carry_out),
    .s3_frm(s3_frm), .s3_exp_max_in(s3_exp_max_in), .s3_sign_in(s3_sign_in), .s3_frac_in(s3_frac_in),
    .s3_carry_out(s3_carry_out), .s3_fp_out(s3_fp_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
    .out_illegal_rm(out_illegal_rm), .inflight(inflight)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural step datapaths: normal numbers only, results exact in every vector used here.
  logic [7:0]  ea, eb, e3;
  logic [25:0] fa, fb, m3;
  logic [26:0] sum27;
  always_comb begin
    ea = s1_op_a[30:23];
    eb = s1_op_b[30:23];
    fa = {1'b1, s1_op_a[22:0], 2'b00};
    fb = {1'b1, s1_op_b[22:0], 2'b00};
    if (ea >= eb) begin
      s1_exp_max = ea; s1_sign_not_shifted = s1_op_a[31]; s1_frac_not_shifted = fa;
      s1_sign_shifted = s1_op_b[31]; s1_frac_shifted = fb >> (ea - eb);
    end else begin
      s1_exp_max = eb; s1_sign_not_shifted = s1_op_b[31]; s1_frac_not_shifted = fb;
      s1_sign_shifted = s1_op_a[31]; s1_frac_shifted = fa >> (eb - ea);
    end
  end
  always_comb begin
    sum27 = {1'b0, s2_frac_not_shifted} + {1'b0, s2_frac_shifted};
    s2_carry_out = 1'b0;
    if (s2_sign_shifted == s2_sign_not_shifted) begin
      s2_frac_out = sum27[25:0]; s2_carry_out = sum27[26]; s2_sign_out = s2_sign_not_shifted;
    end else if (s2_frac_not_shifted >= s2_frac_shifted) begin
      s2_frac_out = s2_frac_not_shifted - s2_frac_shifted; s2_sign_out = s2_sign_not_shifted;
    end else begin
      s2_frac_out = s2_frac_shifted - s2_frac_not_shifted; s2_sign_out = s2_sign_shifted;
    end
  end
  always_comb begin
    m3 = s3_carry_out ? {1'b1, s3_frac_in[25:1]} : s3_frac_in;
    e3 = s3_carry_out ? s3_exp_max_in + 8'd1 : s3_exp_max_in;
    for (int i = 0; i < 26; i++)
      if (m3 != 26'd0 && !m3[25]) begin
        m3 = m3 << 1;
        e3 = e3 - 8'd1;
      end
    s3_fp_out = (m3 == 26'd0) ? {s3_sign_in, 31'd0} : {s3_sign_in, e3, m3[24:2]};
  end

  typedef struct {
    logic [31:0] a, b;
    logic        sub;
    logic [2:0]  frm, csr;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        ill;
  } vec_t;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  vec_t vecs[4];
  exp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0;

  function automatic vec_t mk(input logic [31:0] a, b, input logic sub, input logic [2:0] frm, csr,
                              input logic [4:0] tag, input logic [31:0] res, input logic ill);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.frm = frm; v.csr = csr; v.tag = tag; v.res = res; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic cyc();
    exp_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output: got result %h tag %0d expected no output", out_result, out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", out_result, e.res);
        chk("sb_tag", 32'(out_tag), 32'(e.tag));
        chk("sb_illegal_rm", 32'(out_illegal_rm), 32'(e.ill));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input vec_t v, input logic must_ready);
    exp_t e;
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_frm = v.frm; csr_frm = v.csr; in_tag = v.tag;
    in_valid = 1'b1;
    #1;
    if (must_ready) chk("in_ready_stream", 32'(in_ready), 32'd1);
    for (int k = 0; k < 20 && !in_ready; k++) cyc();
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
    end else begin
      e.res = v.res; e.tag = v.tag; e.ill = v.ill;
      exp_q.push_back(e);
    end
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd0, 32'h40000000, 1'b0);
    vecs[1] = mk(32'h3FC00000, 32'h3F000000, 1'b1, 3'b111, 3'b001, 5'd1, 32'h3F800000, 1'b0);
    vecs[2] = mk(32'h40000000, 32'h40000000, 1'b0, 3'b010, 3'b000, 5'd2, 32'h40800000, 1'b0);
    vecs[3] = mk(32'h40400000, 32'h3F800000, 1'b1, 3'b111, 3'b111, 5'd3, 32'h40000000, 1'b1);
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0;
    in_frm = '0; csr_frm = '0; in_tag = '0; out_ready = 1'b1;
    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_s3_frm", 32'(s3_frm), 32'd0);
    RST = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // single add: latency and occupancy
    issue(mk(32'h3F800000, 32'h3F800000, 1'b0, 3'b000, 3'b000, 5'd3, 32'h40000000, 1'b0), 1'b1);
    chk("add_inflight_c1", 32'(inflight), 32'd1);
    chk("add_out_valid_c1", 32'(out_valid), 32'd0);
    cyc();
    chk("add_inflight_c2", 32'(inflight), 32'd1);
    chk("add_out_valid_c2", 32'(out_valid), 32'd0);
    cyc();
    chk("add_out_valid_c3", 32'(out_valid), 32'd1);
    chk("add_result", out_result, 32'h40000000);
    chk("add_tag", 32'(out_tag), 32'd3);
    chk("add_inflight_c3", 32'(inflight), 32'd1);
    cyc();
    chk("add_inflight_c4", 32'(inflight), 32'd0);

    // subtract with dynamic rounding mode
    issue(mk(32'h3FC00000, 32'h3F000000, 1'b1, 3'b111, 3'b001, 5'd5, 32'h3F800000, 1'b0), 1'b1);
    chk("sub_s1_op_a", s1_op_a, 32'h3FC00000);
    chk("sub_s1_op_b", s1_op_b, 32'hBF000000);
    chk("sub_s2_frac_ns", 32'(s2_frac_not_shifted), 32'h3000000);
    chk("sub_s2_frac_sh", 32'(s2_frac_shifted), 32'h1000000);
    cyc();
    chk("sub_s3_frm", 32'(s3_frm), 32'd1);
    chk("sub_s3_exp", 32'(s3_exp_max_in), 32'h7F);
    cyc();
    chk("sub_result", out_result, 32'h3F800000);
    cyc();

    // reserved static rounding mode
    issue(mk(32'h40000000, 32'h40000000, 1'b0, 3'b101, 3'b000, 5'd7, 32'h40800000, 1'b1), 1'b1);
    cyc();
    chk("ill_s3_frm", 32'(s3_frm), 32'd0);
    cyc();
    chk("ill_flag", 32'(out_illegal_rm), 32'd1);
    chk("ill_result", out_result, 32'h40800000);
    cyc();

    // back-to-back stream, one result per cycle
    for (int i = 0; i < 4; i++) issue(vecs[i], 1'b1);
    repeat (3) cyc();
    chk("stream_drained", 32'(exp_q.size()), 32'd0);

    // backpressure: fill all stages and hold
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(vecs[i], 1'b1);
    chk("bp_inflight", 32'(inflight), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    in_a = vecs[3].a; in_b = vecs[3].b; in_sub = vecs[3].sub; in_tag = 5'd9; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_result", out_result, vecs[0].res);
      chk("bp_hold_tag", 32'(out_tag), 32'(vecs[0].tag));
      chk("bp_hold_inflight", 32'(inflight), 32'd3);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(vecs[3], 1'b1);
    repeat (3) cyc();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_inflight_end", 32'(inflight), 32'd0);

    // flush with two ops in flight
    issue(vecs[0], 1'b1);
    issue(vecs[1], 1'b1);
    chk("fl_inflight", 32'(inflight), 32'd2);
    flush = 1'b1; in_valid = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    cyc();
    chk("fl_inflight_after", 32'(inflight), 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("fl_no_output", 32'(out_valid), 32'd0);
    end

    // asynchronous reset mid-operation with a held result in stage C
    out_ready = 1'b0;
    issue(vecs[2], 1'b1);
    repeat (2) cyc();
    issue(vecs[1], 1'b1);
    chk("rm_pre_out_valid", 32'(out_valid), 32'd1);
    chk("rm_pre_inflight", 32'(inflight), 32'd2);
    #2 RST = 1'b1;
    #1;
    chk("rm_inflight", 32'(inflight), 32'd0);
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_out_result", out_result, 32'd0);
    chk("rm_out_tag", 32'(out_tag), 32'd0);
    chk("rm_s3_frac", 32'(s3_frac_in), 32'd0);
    chk("rm_s2_frac", 32'(s2_frac_not_shifted), 32'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rm_no_output", 32'(out_valid), 32'd0);
    end

    issue(vecs[2], 1'b1);
    repeat (3) cyc();
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fpu_add_sequencer.md
Name: fpu_add_sequencer

Overview:
Pipeline controller for the three-step single-precision FP adder (step1 align, step2 add/sub, step3 normalise/round).
- Owns the valid/ready handshake, the inter-step pipeline registers, rounding-mode resolution, subtract sign flip, tag transport, flush and backpressure.
- Sits between the core's FP issue logic and writeback.
- Step datapaths are instantiated externally and wired through the s1_*/s2_*/s3_* ports.

Parameters:
TAG_W, 5, width of the opaque tag (destination register index) carried with each op.

Ports:
CLK  input  1  clock, rising-edge.
RST  input  1  asynchronous, active-high reset.
flush  input  1  kill all in-flight ops.
in_valid  input  1  op request.
in_ready  output  1  sequencer can accept an op this cycle.
in_a  input  32  operand A (IEEE-754 single).
in_b  input  32  operand B.
in_sub  input  1  1 = A-B, 0 = A+B.
in_frm  input  3  instruction rounding mode; 3'b111 = dynamic.
csr_frm  input  3  fcsr.frm, used when in_frm==3'b111.
in_tag  input  TAG_W  tag.
s1_op_a, s1_op_b  output  32  step1 operands; B has its sign flipped when in_sub.
s1_sign_shifted, s1_sign_not_shifted  input  1  step1 results.
s1_frac_shifted, s1_frac_not_shifted  input  26  step1 results.
s1_exp_max  input  8  step1 result.
s2_sign_shifted, s2_sign_not_shifted  output  1  registered step1 results to step2.
s2_frac_shifted, s2_frac_not_shifted  output  26  registered step1 results to step2.
s2_sign_out  input  1  step2 result.
s2_frac_out  input  26  step2 result.
s2_carry_out  input  1  step2 result.
s3_frm  output  3  resolved rounding mode for step3.
s3_exp_max_in  output  8  registered to step3.
s3_sign_in  output  1  registered to step3.
s3_frac_in  output  26  registered to step3.
s3_carry_out  output  1  registered to step3.
s3_fp_out  input  32  step3 result.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts.
out_result  output  32  result.
out_tag  output  TAG_W  tag of result.
out_illegal_rm  output  1  resolved frm was 101/110 (reserved).
inflight  output  2  number of valid stages, 0..3.

Behaviour:
- Stages:
  - A (step1 outputs, exp_max, resolved frm, tag).
  - B (step2 outputs, exp_max, frm, tag).
  - C (step3 result, tag, illegal flag).
  - Each stage has a valid bit.
- s1_op_a = in_a; s1_op_b = {in_b[31]^in_sub, in_b[30:0]}; driven combinationally from the inputs.
- s2_* driven from stage A regs; s3_* driven from stage B regs.
- Resolved frm = (in_frm==3'b111) ? csr_frm : in_frm, captured at accept.
  - Reserved value (101/110): the op still runs with frm 3'b000 and sets the illegal flag.
  - csr_frm==3'b111 is also reserved.
- Advance rules (all combinational):
  - advC = !vC | out_ready.
  - advB = !vB | advC.
  - advA = !vA | advB.
  - in_ready = advA & !flush.
- Each clock:
  - Stage C loads from B when advC.
  - Stage B loads from A when advB.
  - Stage A loads from inputs when advA.
  - Each stage's valid takes the upstream valid on load (input side: in_valid & in_ready); otherwise it holds. Data regs load only on their advance.
- Accept: in_valid & in_ready at edge E0.
  - Result is in C after E2, so out_valid rises in the third cycle.
  - Throughput 1 op/cycle with no backpressure.
- Backpressure: with out_ready=0 and all stages valid, in_ready=0 and every stage holds its data bit-exactly.
- Simultaneous C output and A input in the same cycle is legal; no bubble is inserted.
- out_valid = vC; out_result/out_tag/out_illegal_rm come from stage C regs.
  - out_result stays stable while out_valid & !out_ready.
- inflight = vA+vB+vC.
- flush (synchronous): next edge clears vA, vB, vC. The input op in that cycle is not accepted; data regs are don't-care.
- RST (asynchronous): clears all valids and sets every data reg to 0 immediately. Outputs then read out_valid=0, in_ready=1 (once RST is released), inflight=0, out_result=0, out_tag=0, s2_*/s3_* = 0, s3_frm=0.
  - Reset mid-operation discards all ops; there is no partial output.

Test Plan:
- Reset then single add: a=0x3F800000, b=0x3F800000, sub=0, frm=000, tag=3 -> out_valid in third cycle, out_result=0x40000000, out_tag=3, inflight 1,1,1,0.
- Subtract with dynamic rm: a=0x3FC00000, b=0x3F000000, sub=1, in_frm=111, csr_frm=001 -> s1_op_b=0xBF000000, s3_frm=001, out_result=0x3F800000.
- Back-to-back stream of 4 ops, out_ready=1 -> in_ready stays 1, results on 4 consecutive cycles in order, tags 0..3.
- Backpressure: 3 ops, out_ready=0 -> inflight=3, in_ready=0, out_result held. Raise out_ready -> one result per cycle, no loss or duplication.
- Illegal rm: in_frm=101 -> out_illegal_rm=1, s3_frm=000, result = round-to-nearest-even sum.
- Flush with inflight=2 plus RST asserted mid-op -> valids clear (flush: next edge; RST: immediately), in_ready=0 during flush cycle, out_valid never asserts for killed ops.
